// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch unit feeding the main decoder.
// Owns the PC and drives instruction-memory reads over a req/ready handshake.
// Fetched words land in the IF/ID register, or in a one-entry skid buffer
// when decode is stalled. Flush and taken beq/j redirects come back from decode.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   imem_req/imem_addr    read request and byte address ([1:0]=00)
//   imem_ready/imem_rdata request accepted / instruction word this cycle
//   Stall                 hold IF/ID and PC
//   Flush                 kill IF/ID, refetch from the oldest unissued PC
//   BranchTaken/Target    taken beq resolved in decode
//   Jump                  j decoded from the IF/ID instruction
//   Instr/Opcode/PCPlus4  IF/ID contents; Opcode = Instr[31:26]
//   InstrValid            IF/ID holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic [31:0] pc_next;
    logic [31:0] pc_prev;
    logic [31:0] target;
    logic        redirect;
    logic [1:0]  unused_bits;

    assign Opcode      = Instr[31:26];
    assign pc_next     = pc + 32'd4;
    assign pc_prev     = pc - 32'd4;
    assign unused_bits = BranchTarget[1:0];

    // A redirect is only meaningful for the real instruction sitting in
    // IF/ID; a taken branch beats a jump if decode reports both.
    assign redirect = InstrValid && (BranchTaken || Jump);
    assign target   = BranchTaken
                    ? {BranchTarget[31:2], 2'b00}
                    : {PCPlus4[31:28], Instr[25:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid       <= NOP_WORD;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            Instr      <= NOP_WORD;
            PCPlus4    <= 32'd0;
            InstrValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end

                FETCH: begin
                    if (Flush) begin
                        // PC already points at the word being fetched,
                        // so only the IF/ID entry is lost.
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                        if (!imem_ready) state <= DRAIN;
                    end else if (redirect) begin
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                        pc         <= target;
                        if (imem_ready) imem_addr <= target;
                        else            state     <= DRAIN;
                    end else if (imem_ready) begin
                        pc        <= pc_next;
                        imem_addr <= pc_next;
                        if (Stall) begin
                            skid     <= imem_rdata;
                            imem_req <= 1'b0;
                            state    <= HOLD;
                        end else begin
                            Instr      <= imem_rdata;
                            PCPlus4    <= pc_next;
                            InstrValid <= 1'b1;
                        end
                    end else if (!Stall) begin
                        // Decode consumed IF/ID but nothing new arrived.
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (Flush) begin
                        // Rewind so the discarded skid word is refetched.
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                        pc         <= pc_prev;
                        imem_addr  <= pc_prev;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (redirect) begin
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                        pc         <= target;
                        imem_addr  <= target;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (!Stall) begin
                        // PC already sits one word past the skid entry.
                        Instr      <= skid;
                        PCPlus4    <= pc;
                        InstrValid <= 1'b1;
                        skid       <= NOP_WORD;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end
                end

                DRAIN: begin
                    // Keep the stale request up at its old address until
                    // memory takes it; its data is thrown away.
                    if (Flush) begin
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                    end else if (redirect) begin
                        Instr      <= NOP_WORD;
                        InstrValid <= 1'b0;
                        skid       <= NOP_WORD;
                        pc         <= target;
                    end
                    if (imem_ready) begin
                        state     <= FETCH;
                        imem_addr <= (!Flush && redirect) ? target : pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked against
// an instruction-stream model of what decode should observe.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [31:0] PCPlus4;
    logic        InstrValid;

    logic        req2;
    logic [31:0] addr2;
    logic        ready2;
    logic [31:0] rdata2;
    logic        zero1;
    logic [31:0] zero32;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic [31:0] pc4_2;
    logic        valid2;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .Stall        (Stall),
        .Flush        (Flush),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .Instr        (Instr),
        .Opcode       (Opcode),
        .PCPlus4      (PCPlus4),
        .InstrValid   (InstrValid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (req2),
        .imem_addr    (addr2),
        .imem_ready   (ready2),
        .imem_rdata   (rdata2),
        .Stall        (zero1),
        .Flush        (zero1),
        .BranchTaken  (zero1),
        .BranchTarget (zero32),
        .Jump         (zero1),
        .Instr        (instr2),
        .Opcode       (opcode2),
        .PCPlus4      (pc4_2),
        .InstrValid   (valid2)
    );

    assign rdata2 = addr2 ^ 32'h5A5A_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: each request is held for lat cycles, ready on the last one.
    logic [31:0] mem [0:255];
    int fixed_lat = 1;
    bit rand_lat  = 0;
    int cnt       = 0;
    bit busy      = 0;

    initial begin
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req) begin
                busy       = 0;
                imem_ready = 1'b0;
            end else begin
                if (!busy || imem_ready) begin
                    busy = 1;
                    if (rand_lat)
                        cnt = ($urandom % 2 == 0) ? 0 : $urandom_range(0, 3);
                    else
                        cnt = fixed_lat - 1;
                end else begin
                    cnt = cnt - 1;
                end
                imem_ready = (cnt == 0);
            end
            imem_rdata = imem_ready ? mem[imem_addr[9:2]] : $urandom;
        end
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n     = 1'b0;
        fixed_lat = lat;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          consumed;
    logic [31:0] exp_next;
    logic [31:0] exp_w;
    logic [31:0] exp_pc4;
    bit          have_prev;
    logic        p_req, p_ready, p_stall, p_valid, p_flush, p_redir;
    logic [31:0] p_addr, p_instr, p_pc4;
    bit          seen;

    initial begin
        rst_n        = 1'b0;
        Stall        = 1'b0;
        Flush        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'd0;
        Jump         = 1'b0;
        zero1        = 1'b0;
        zero32       = 32'd0;
        ready2       = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0]   = 32'h8C01_0004;
        mem[1]   = 32'h0022_1820;
        mem[2]   = 32'hAC03_0008;
        mem[16]  = 32'h2405_0040;
        mem[17]  = 32'h8CA6_0000;
        mem[64]  = 32'h0800_0010;
        mem[65]  = 32'h2002_0001;
        mem[128] = 32'h1022_0003;

        // Reset values and back-to-back fetch with a zero-wait memory.
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", InstrValid, 0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pc4", PCPlus4, 32'h0);
        check("rst_req2", req2, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("b2b_addr0", imem_addr, 32'h0);
        check("b2b_req0", imem_req, 1);
        check("b2b_valid0", InstrValid, 0);
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        check("b2b_addr1", imem_addr, 32'h4);
        check("b2b_instr1", Instr, 32'h8C01_0004);
        check("b2b_pc4_1", PCPlus4, 32'h4);
        check("b2b_op1", Opcode, 6'b100011);
        check("b2b_valid1", InstrValid, 1);
        check("wrap_addr1", addr2, 32'h0);
        check("wrap_pc4", pc4_2, 32'h0);
        check("wrap_instr", instr2, 32'hA5A5_FFFC);
        @(negedge clk);
        check("b2b_addr2", imem_addr, 32'h8);
        check("b2b_instr2", Instr, 32'h0022_1820);
        check("b2b_pc4_2", PCPlus4, 32'h8);
        check("b2b_op2", Opcode, 6'b000000);

        // Reset mid-request, then a 3-cycle memory.
        rst_n = 1'b0;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_valid", InstrValid, 0);
        check("midrst_instr", Instr, 32'h0);
        fixed_lat = 3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat_req", imem_req, 1);
            check("lat_addr", imem_addr, 32'h0);
            check("lat_valid", InstrValid, 0);
        end
        @(negedge clk);
        check("lat_valid_up", InstrValid, 1);
        check("lat_instr", Instr, mem[0]);
        check("lat_next_addr", imem_addr, 32'h4);

        // Stall for two cycles while the next word arrives.
        do_reset(1);
        repeat (2) @(negedge clk);
        check("stl_instr0", Instr, mem[0]);
        Stall = 1'b1;
        @(negedge clk);
        check("stl_hold_req", imem_req, 0);
        check("stl_hold_instr", Instr, mem[0]);
        check("stl_hold_valid", InstrValid, 1);
        @(negedge clk);
        check("stl_hold_req2", imem_req, 0);
        check("stl_hold_pc4", PCPlus4, 32'h4);
        Stall = 1'b0;
        @(negedge clk);
        check("stl_skid_instr", Instr, mem[1]);
        check("stl_skid_pc4", PCPlus4, 32'h8);
        check("stl_req", imem_req, 1);
        check("stl_addr", imem_addr, 32'h8);
        @(negedge clk);
        check("stl_next_instr", Instr, mem[2]);
        check("stl_next_pc4", PCPlus4, 32'hC);

        // Branch to 0x100, then j 0x08000010 from there.
        do_reset(1);
        repeat (2) @(negedge clk);
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        @(negedge clk);
        BranchTaken = 1'b0;
        check("br_bubble", InstrValid, 0);
        check("br_addr", imem_addr, 32'h100);
        @(negedge clk);
        check("j_instr", Instr, 32'h0800_0010);
        check("j_pc4", PCPlus4, 32'h104);
        Jump = 1'b1;
        @(negedge clk);
        Jump = 1'b0;
        check("j_addr", imem_addr, 32'h40);
        check("j_bubble", InstrValid, 0);
        fixed_lat = 3;
        @(negedge clk);
        check("j_tgt_instr", Instr, mem[16]);
        check("j_tgt_pc4", PCPlus4, 32'h44);
        check("j_tgt_valid", InstrValid, 1);

        // Branch and jump together while the 0x44 request is outstanding.
        BranchTaken  = 1'b1;
        BranchTarget = 32'h203;
        Jump         = 1'b1;
        @(negedge clk);
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        check("drn_req", imem_req, 1);
        check("drn_addr", imem_addr, 32'h44);
        check("drn_valid", InstrValid, 0);
        @(negedge clk);
        check("drn_addr2", imem_addr, 32'h44);
        check("drn_valid2", InstrValid, 0);
        @(negedge clk);
        check("drn_new_addr", imem_addr, 32'h200);
        check("drn_new_valid", InstrValid, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = InstrValid;
        end
        check("drn_arrive", seen, 1);
        check("drn_instr", Instr, mem[128]);
        check("drn_pc4", PCPlus4, 32'h204);

        // Randomized run against the instruction-stream model.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [5:0] op;
            if ($urandom % 8 == 0) begin
                mem[i] = {6'h02, 18'h0, 8'($urandom)};
            end else begin
                op = 6'($urandom);
                if (op == 6'h02) op = 6'h03;
                mem[i] = {op, 26'($urandom)};
            end
        end
        rand_lat = 1;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_next  = 32'h0;
        consumed  = 0;
        have_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (have_prev) begin
                if (p_req && !p_ready) begin
                    check("rnd_req_hold", imem_req, 1);
                    check("rnd_addr_hold", imem_addr, p_addr);
                end
                if (p_stall && p_valid && !p_flush && !p_redir) begin
                    check("rnd_stall_instr", Instr, p_instr);
                    check("rnd_stall_pc4", PCPlus4, p_pc4);
                    check("rnd_stall_valid", InstrValid, 1);
                end
            end
            Stall        = ($urandom % 4) == 0;
            Flush        = ($urandom % 24) == 0;
            BranchTaken  = ($urandom % 10) == 0;
            BranchTarget = $urandom & 32'h3FF;
            if (InstrValid) Jump = (Instr[31:26] == 6'h02);
            else            Jump = ($urandom % 6) == 0;

            exp_w   = mem[exp_next[9:2]];
            exp_pc4 = exp_next + 32'd4;
            if (InstrValid) begin
                check("rnd_instr", Instr, exp_w);
                check("rnd_pc4", PCPlus4, exp_pc4);
                check("rnd_opcode", Opcode, exp_w[31:26]);
                if (!Flush && (BranchTaken || Jump || !Stall))
                    consumed++;
                if (Flush)
                    exp_next = exp_pc4;
                else if (BranchTaken)
                    exp_next = {BranchTarget[31:2], 2'b00};
                else if (Jump)
                    exp_next = {exp_pc4[31:28], exp_w[25:0], 2'b00};
                else if (!Stall)
                    exp_next = exp_pc4;
            end

            have_prev = 1;
            p_req     = imem_req;
            p_ready   = imem_ready;
            p_addr    = imem_addr;
            p_stall   = Stall;
            p_valid   = InstrValid;
            p_flush   = Flush;
            p_redir   = InstrValid && (BranchTaken || Jump);
            p_instr   = Instr;
            p_pc4     = PCPlus4;
        end
        check("rnd_progress", (consumed >= 300) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
